// File: rtl/bitbakery_serial_tx.sv
// Autonomous 8E1 serial transmitter: sends the packet D0..D3 NUM_PACKETS times after reset, then idles high.
// Build option: define BITBAKERY_TX_CONTINUOUS_EN to repeat the packet forever instead of stopping.
module bitbakery_serial_tx #(
  parameter int TICK_DIV    = 434,
  parameter int NUM_PACKETS = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] D0,
  input  logic [7:0] D1,
  input  logic [7:0] D2,
  input  logic [7:0] D3,
  output logic       saida_serial
);

  localparam int BAUD_W = $clog2(TICK_DIV);
  localparam int PKT_W  = $clog2(NUM_PACKETS + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [1:0]        byte_q, byte_d;
  logic [PKT_W-1:0]  pkt_q, pkt_d;
  logic [7:0]        shift_q, shift_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;

  logic              tick;
  logic              last_pkt;
  logic              last_byte;
  logic [1:0]        load_idx;
  logic [7:0]        load_byte;

  assign tick     = (baud_q == BAUD_W'(TICK_DIV - 1));
  assign last_pkt = (pkt_q == PKT_W'(NUM_PACKETS - 1));

`ifdef BITBAKERY_TX_CONTINUOUS_EN
  assign last_byte = 1'b0;
`else
  assign last_byte = (byte_q == 2'd3) && last_pkt;
`endif

  // Byte captured when a frame begins; the sources are only looked at here.
  always_comb begin
    case (load_idx)
      2'd0:    load_byte = D0;
      2'd1:    load_byte = D1;
      2'd2:    load_byte = D2;
      default: load_byte = D3;
    endcase
  end

  // NOTE: every signal written here gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    baud_d   = tick ? '0 : baud_q + BAUD_W'(1);
    bit_d    = bit_q;
    byte_d   = byte_q;
    pkt_d    = pkt_q;
    shift_d  = shift_q;
    par_d    = par_q;
    tx_d     = tx_q;
    load_idx = byte_q;

    case (state_q)
      S_IDLE: begin
        state_d = S_START;
        baud_d  = '0;
        shift_d = load_byte;
        par_d   = ^load_byte;
        tx_d    = 1'b0;
      end
      S_START: begin
        if (tick) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
        end
      end
      S_DATA: begin
        if (tick) begin
          if (bit_q == 3'd7) begin
            state_d = S_PARITY;
            tx_d    = par_q;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (last_byte) begin
            state_d = S_DONE;
            tx_d    = 1'b1;
          end else begin
            // Next start bit follows the last stop cycle with no gap.
            load_idx = byte_q + 2'd1;
            state_d  = S_START;
            byte_d   = byte_q + 2'd1;
            shift_d  = load_byte;
            par_d    = ^load_byte;
            tx_d     = 1'b0;
            if (byte_q == 2'd3) pkt_d = last_pkt ? '0 : pkt_q + PKT_W'(1);
          end
        end
      end
      default: begin
        state_d = S_DONE;
        baud_d  = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      byte_q  <= 2'd0;
      pkt_q   <= '0;
      shift_q <= 8'h00;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      pkt_q   <= pkt_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  assign saida_serial = tx_q;

endmodule

// File: tb/tb_bitbakery_serial_tx.sv
// Directed bench for bitbakery_serial_tx: decodes frames mid-bit and checks content, parity, spacing and stop behaviour.
module tb_bitbakery_serial_tx;

  localparam int T     = 16;
  localparam int NPKT  = 4;
  localparam int FRAME = 11 * T;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] D0 = 8'h41, D1 = 8'h42, D2 = 8'h43, D3 = 8'h44;
  logic       saida_serial;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [7:0] exp_b [17];
  int         poke_frame = -1;
  logic [7:0] poke_val = 8'h00;

  bitbakery_serial_tx #(.TICK_DIV(T), .NUM_PACKETS(NPKT)) dut (
    .clock        (clock),
    .reset        (reset),
    .D0           (D0),
    .D1           (D1),
    .D2           (D2),
    .D3           (D3),
    .saida_serial (saida_serial)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] frame_of(input logic [7:0] b);
    return {1'b1, ^b, b, 1'b0};
  endfunction

  // Waits (bounded) for a start bit, then samples each of the 11 bits mid-bit.
  task automatic recv_frame(input bit poke, output logic [10:0] bits, output int start_cyc, output bit ok);
    int waited = 0;
    ok = 1'b0;
    bits = '1;
    start_cyc = -1;
    while (saida_serial !== 1'b0 && waited < 3 * FRAME) begin
      @(negedge clock);
      waited++;
    end
    if (saida_serial !== 1'b0) return;
    ok = 1'b1;
    start_cyc = cyc;
    repeat (T / 2) @(negedge clock);
    for (int k = 0; k < 11; k++) begin
      bits[k] = saida_serial;
      if (poke && k == 3) D1 = poke_val;
      if (k < 10) repeat (T) @(negedge clock);
    end
  endtask

  task automatic apply_reset(input string tag);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check({tag, "_rst_line"}, saida_serial, 1'b1);
  endtask

  // Called at a negedge with reset low; releases reset and decodes nframes frames.
  task automatic release_and_check(input string tag, input int nframes);
    int rel, prev, sc;
    logic [10:0] bits;
    bit ok;
    reset = 1'b1;
    rel = cyc;
    prev = 0;
    for (int f = 0; f < nframes; f++) begin
      recv_frame(f == poke_frame, bits, sc, ok);
      check($sformatf("%s_f%0d_seen", tag, f), ok, 1'b1);
      if (!ok) return;
      check($sformatf("%s_f%0d_bits", tag, f), bits, frame_of(exp_b[f]));
      if (f == 0) check($sformatf("%s_latency", tag), sc, rel + 1);
      else        check($sformatf("%s_f%0d_gap", tag, f), sc - prev, FRAME);
      prev = sc;
    end
  endtask

  task automatic check_idle(input string tag, input int ncyc);
    int zeros = 0;
    repeat (ncyc) begin
      @(negedge clock);
      if (saida_serial !== 1'b1) zeros++;
    end
    check(tag, zeros, 0);
  endtask

  task automatic check_end(input string tag);
`ifdef BITBAKERY_TX_CONTINUOUS_EN
    logic [10:0] bits;
    int sc;
    bit ok;
    recv_frame(1'b0, bits, sc, ok);
    check({tag, "_f16_seen"}, ok, 1'b1);
    check({tag, "_f16_bits"}, bits, frame_of(D0));
`else
    check_idle({tag, "_done_idle"}, 3 * FRAME);
`endif
  endtask

  initial begin
    logic [10:0] bits;
    int sc, waited;
    bit ok;

    // Run 1: full packet sequence with D1 changed during its frame in packet 1.
    apply_reset("run1");
    for (int f = 0; f < 16; f++) begin
      case (f % 4)
        0: exp_b[f] = 8'h41;
        1: exp_b[f] = (f >= 9) ? 8'h55 : 8'h42;
        2: exp_b[f] = 8'h43;
        default: exp_b[f] = 8'h44;
      endcase
    end
    poke_frame = 5;
    poke_val = 8'h55;
    release_and_check("run1", 16);
    poke_frame = -1;
    check_end("run1");

    // First frame decoded by hand: start, 0x41 LSB first, parity 0, stop.
    apply_reset("hand");
    D1 = 8'h42;
    reset = 1'b1;
    recv_frame(1'b0, bits, sc, ok);
    check("hand_seen", ok, 1'b1);
    check("hand_0x41", bits, 11'b1_0_01000001_0);

    // Parity corner bytes.
    apply_reset("p07");
    D0 = 8'h07;
    reset = 1'b1;
    recv_frame(1'b0, bits, sc, ok);
    check("p07_par", bits[9], 1'b1);
    check("p07_bits", bits, 11'b1_1_00000111_0);

    apply_reset("p00");
    D0 = 8'h00;
    reset = 1'b1;
    recv_frame(1'b0, bits, sc, ok);
    check("p00_par", bits[9], 1'b0);
    check("p00_bits", bits, 11'b1_0_00000000_0);

    apply_reset("pff");
    D0 = 8'hFF;
    reset = 1'b1;
    recv_frame(1'b0, bits, sc, ok);
    check("pff_par", bits[9], 1'b0);
    check("pff_bits", bits, 11'b1_0_11111111_0);

    // Reset in the middle of the second frame aborts it and restarts from D0.
    apply_reset("abort");
    D0 = 8'h41;
    for (int f = 0; f < 16; f++) exp_b[f] = 8'h41 + 8'(f % 4);
    release_and_check("abort_pre", 1);
    waited = 0;
    while (saida_serial !== 1'b0 && waited < 2 * FRAME) begin
      @(negedge clock);
      waited++;
    end
    check("abort_f1_seen", saida_serial, 1'b0);
    repeat (3 * T) @(negedge clock);
    check("abort_mid_data", saida_serial, 1'b0);
    reset = 1'b0;
    @(negedge clock);
    check("abort_line_high", saida_serial, 1'b1);
    repeat (2) @(negedge clock);
    release_and_check("abort_post", 16);
    check_end("abort_post");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
